// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipe: load-use bubbles,
// branch/jump redirects, data-memory freeze with a timeout trap, and event counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_valid,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // state | meaning
    // RUN   | normal operation
    // MWAIT | waiting on data memory
    // ERR   | trapped after a memory timeout, left only by reset
    typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WCNT_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze, load_use, redirect_taken;

    always_comb begin
        freeze   = (state_q == ERR) || (mem_req && !mem_ready);
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

        pc_stall       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_valid    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_stall   = 1'b0;
        mem_wb_flush   = 1'b0;
        redirect_taken = 1'b0;

        // Outputs are forced quiet while reset is held, even id_ex_valid.
        if (!reset) begin
            if (freeze) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_redirect) begin
                redirect_taken = 1'b1;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
                id_ex_valid    = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                id_ex_valid = 1'b1;
            end else begin
                id_ex_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (state_q != ERR) begin
            if (freeze) begin
                if (wcnt_q == WCNT_LAST) begin
                    state_d = ERR;
                end else begin
                    wcnt_d  = wcnt_q + WC_W'(1);
                    state_d = MWAIT;
                end
            end else begin
                wcnt_d  = '0;
                state_d = RUN;
            end
        end

        if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (redirect_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = (state_q == ERR);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4): expected outputs come
// from a behavioural model, are queued when driven and checked on the falling edge.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0, ex_redirect = 0;
    logic       mem_req = 0, mem_ready = 1;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_valid, id_ex_flush;
    logic       ex_mem_stall, mem_wb_flush, mem_err;
    logic [3:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_valid(id_ex_valid), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] ctrl;
        logic       err;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t sb[$];
    int   errs = 0;
    int   checks = 0;

    // model state
    bit m_err = 0;
    int m_wcnt = 0, m_stall = 0, m_flush = 0;

    logic [6:0] ctrl_obs;
    assign ctrl_obs = {pc_stall, if_id_stall, if_id_flush, id_ex_valid,
                       id_ex_flush, ex_mem_stall, mem_wb_flush};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".ctrl"}, 16'(ctrl_obs), 16'(e.ctrl));
            chk({e.tag, ".err"},  16'(mem_err),  16'(e.err));
            chk({e.tag, ".cnt"},  {8'h0, stall_cnt, flush_cnt}, {8'h0, e.sc, e.fc});
        end
    end

    // Drive one cycle: inputs applied after a posedge, expectation queued, model advanced at the next posedge.
    task automatic step(input string tag, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic redir, input logic req, input logic rdy);
        exp_t e;
        bit frz, lu, taken, stl;
        ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; ex_redirect = redir; mem_req = req; mem_ready = rdy;
        frz   = m_err || (req && !rdy);
        lu    = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        taken = !frz && redir;
        stl   = frz || (!redir && lu);
        if (frz)       e.ctrl = 7'b1100011;
        else if (redir) e.ctrl = 7'b0011100;
        else if (lu)   e.ctrl = 7'b1101100;
        else           e.ctrl = 7'b0001000;
        e.tag = tag; e.err = m_err; e.sc = 4'(m_stall); e.fc = 4'(m_flush);
        sb.push_back(e);
        @(posedge clk);
        if (stl && m_stall < 15) m_stall++;
        if (taken && m_flush < 15) m_flush++;
        if (!m_err) begin
            if (frz) begin
                if (m_wcnt + 1 == 4) m_err = 1;
                else m_wcnt++;
            end else m_wcnt = 0;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        ex_mem_read = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1;
        mem_req = 0; mem_ready = 1; ex_redirect = 0;
        #2;
        chk({tag, ".rst_ctrl"}, 16'(ctrl_obs), 16'h0);
        chk({tag, ".rst_err"},  16'(mem_err),  16'h0);
        chk({tag, ".rst_cnt"},  {8'h0, stall_cnt, flush_cnt}, 16'h0);
        ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 0;
        reset = 1'b0;
        m_err = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset: outputs quiet even with a load-use pattern on the inputs
        ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
        #2;
        chk("reset.ctrl", 16'(ctrl_obs), 16'h0);
        chk("reset.err",  16'(mem_err),  16'h0);
        chk("reset.cnt",  {8'h0, stall_cnt, flush_cnt}, 16'h0);
        @(posedge clk);
        ex_mem_read = 0; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 0;
        #2 reset = 1'b0;
        @(posedge clk); #1;

        idle("normal");
        step("lu_rs2",     1, 5, 0, 5, 0, 1, 0, 0, 1);
        idle("after_lu");
        step("lu_rd0",     1, 0, 0, 0, 0, 1, 0, 0, 1);
        step("lu_nouse",   1, 5, 0, 5, 0, 0, 0, 0, 1);
        step("lu_rs1",     1, 9, 9, 3, 1, 0, 0, 0, 1);
        step("lu_nomatch", 1, 9, 8, 3, 1, 1, 0, 0, 1);
        step("redir_lu",   1, 5, 0, 5, 0, 1, 1, 0, 1);
        idle("after_redir");

        repeat (3) step("mwait", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step("mready", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle("after_mwait");

        repeat (2) step("redir_frz", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step("redir_go", 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle("after_redir_frz");

        repeat (6) step("timeout", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) step("err_hold", 0, 0, 0, 0, 0, 0, 1, 1, 1);
        do_reset("err");
        idle("after_err_rst");

        repeat (2) step("mid_mwait", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        do_reset("mwait");
        idle("after_mwait_rst");

        repeat (20) step("sat", 1, 3, 3, 0, 1, 0, 0, 0, 1);
        idle("after_sat");

        for (int i = 0; i < 300; i++) begin
            if (i % 50 == 49) do_reset("rand");
            step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
        end

        @(negedge clk); #1;
        if (sb.size() != 0) chk("sb_drain", 16'(sb.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
